// File: rtl/bounded_counter_pkg.sv
// Shared mode encoding for the bounded up/down counter family.
package bounded_counter_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_WRAP   = 2'b00;
  localparam mode_t MODE_SAT    = 2'b01;
  localparam mode_t MODE_BOUNCE = 2'b10;

endpackage

// File: rtl/counter_prescaler.sv
// Enable prescaler: tick is high one cycle in every PRESCALE while enable is held.
module counter_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'((PRESCALE > 1) ? PRESCALE - 1 : 0);

  logic [CW-1:0] phase_reg;

  // Phase restarts from zero whenever enable drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_reg <= '0;
    end else if (!enable || phase_reg == LAST) begin
      phase_reg <= '0;
    end else begin
      phase_reg <= phase_reg + 1'b1;
    end
  end

  assign tick = (PRESCALE <= 1) ? enable : (enable && phase_reg == LAST);

endmodule

// File: rtl/bounded_updown_counter.sv
// Parametrised up/down counter with runtime limits, wrap/saturate/bounce modes and prescaler.
module bounded_updown_counter
  import bounded_counter_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int STEP_W      = 2,
  parameter int RESET_VALUE = 5,
  parameter int PRESCALE    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_value,
  input  logic              up_down,
  input  logic [STEP_W-1:0] step,
  input  mode_t             mode,
  input  logic [WIDTH-1:0]  lo_limit,
  input  logic [WIDTH-1:0]  hi_limit,
  input  logic              clear_flags,
  output logic [WIDTH-1:0]  count,
  output logic              at_max,
  output logic              at_min,
  output logic              dir,
  output logic              event_pulse,
  output logic              sat_sticky,
  output logic              limit_err
);

  logic             tick;
  logic             do_step;
  logic             going_up;
  logic             out_range;
  logic [WIDTH:0]   step_ext;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] load_count;
  logic [WIDTH-1:0] step_count;
  logic             step_dir;
  logic             step_event;

  logic [WIDTH-1:0] count_reg;
  logic             dir_reg;
  logic             event_pulse_reg;
  logic             sat_sticky_reg;

  counter_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .tick   (tick)
  );

  assign limit_err = lo_limit > hi_limit;
  assign do_step   = enable & tick & ~load & ~limit_err;

  always_comb begin
    step_ext   = (step == '0) ? (WIDTH+1)'(1) : (WIDTH+1)'(step);
    going_up   = (mode == MODE_BOUNCE) ? dir_reg : up_down;
    sum        = {1'b0, count_reg} + step_ext;
    diff       = {1'b0, count_reg} - step_ext;
    out_range  = (count_reg < lo_limit) || (count_reg > hi_limit);
    load_count = (load_value < lo_limit) ? lo_limit :
                 (load_value > hi_limit) ? hi_limit : load_value;
    step_count = count_reg;
    step_dir   = going_up;
    step_event = 1'b0;

    if (going_up) begin
      if (sum > {1'b0, hi_limit}) begin
        step_event = 1'b1;
        case (mode)
          MODE_SAT:    step_count = hi_limit;
          MODE_BOUNCE: begin
            step_count = hi_limit;
            step_dir   = 1'b0;
          end
          default:     step_count = lo_limit;
        endcase
      end else if (out_range) begin
        // Count sat below a raised lower limit: pull it back in and flag it.
        step_event = 1'b1;
        step_count = (sum[WIDTH-1:0] < lo_limit) ? lo_limit : sum[WIDTH-1:0];
      end else begin
        step_count = sum[WIDTH-1:0];
      end
    end else begin
      if (diff[WIDTH] || diff[WIDTH-1:0] < lo_limit) begin
        step_event = 1'b1;
        case (mode)
          MODE_SAT:    step_count = lo_limit;
          MODE_BOUNCE: begin
            step_count = lo_limit;
            step_dir   = 1'b1;
          end
          default:     step_count = hi_limit;
        endcase
      end else if (out_range) begin
        step_event = 1'b1;
        step_count = (diff[WIDTH-1:0] > hi_limit) ? hi_limit : diff[WIDTH-1:0];
      end else begin
        step_count = diff[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg       <= WIDTH'(RESET_VALUE);
      dir_reg         <= 1'b1;
      event_pulse_reg <= 1'b0;
      sat_sticky_reg  <= 1'b0;
    end else begin
      event_pulse_reg <= do_step & step_event;
      if (!limit_err) begin
        // A fresh event beats a simultaneous clear.
        sat_sticky_reg <= (do_step & step_event) | (sat_sticky_reg & ~clear_flags);
        if (load) begin
          count_reg <= load_count;
        end else if (do_step) begin
          count_reg <= step_count;
          dir_reg   <= step_dir;
        end
      end
    end
  end

  assign count       = count_reg;
  assign dir         = dir_reg;
  assign event_pulse = event_pulse_reg;
  assign sat_sticky  = sat_sticky_reg;
  assign at_max      = count_reg == hi_limit;
  assign at_min      = count_reg == lo_limit;

endmodule

// File: tb/tb_bounded_updown_counter.sv
// Randomised bench for bounded_updown_counter (PRESCALE=1 and PRESCALE=3) against an integer model.
module tb_bounded_updown_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable, load, up_down, clear_flags;
  logic [3:0] load_value, lo_limit, hi_limit;
  logic [1:0] step, mode;

  logic [3:0] c1_count, c3_count;
  logic       c1_at_max, c1_at_min, c1_dir, c1_pulse, c1_sticky, c1_err;
  logic       c3_at_max, c3_at_min, c3_dir, c3_pulse, c3_sticky, c3_err;

  typedef struct {
    int count;
    bit dir;
    bit pulse;
    bit sticky;
    int pre;
  } model_t;

  model_t m1, m3;
  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  bounded_updown_counter #(.WIDTH(4), .STEP_W(2), .RESET_VALUE(5), .PRESCALE(1)) u_p1 (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .load_value(load_value),
    .up_down(up_down), .step(step), .mode(mode), .lo_limit(lo_limit), .hi_limit(hi_limit),
    .clear_flags(clear_flags), .count(c1_count), .at_max(c1_at_max), .at_min(c1_at_min),
    .dir(c1_dir), .event_pulse(c1_pulse), .sat_sticky(c1_sticky), .limit_err(c1_err)
  );

  bounded_updown_counter #(.WIDTH(4), .STEP_W(2), .RESET_VALUE(5), .PRESCALE(3)) u_p3 (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .load_value(load_value),
    .up_down(up_down), .step(step), .mode(mode), .lo_limit(lo_limit), .hi_limit(hi_limit),
    .clear_flags(clear_flags), .count(c3_count), .at_max(c3_at_max), .at_min(c3_at_min),
    .dir(c3_dir), .event_pulse(c3_pulse), .sat_sticky(c3_sticky), .limit_err(c3_err)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic model_t model_reset();
    model_t r;
    r.count = 5; r.dir = 1'b1; r.pulse = 1'b0; r.sticky = 1'b0; r.pre = 0;
    return r;
  endfunction

  // One clock of the counter rules, computed on plain integers.
  function automatic model_t model_next(model_t m, int presc);
    model_t r = m;
    int lo = int'(lo_limit);
    int hi = int'(hi_limit);
    int lv = int'(load_value);
    int s, tgt;
    bit tick, up;
    r.pulse = 1'b0;
    if (!enable) begin
      tick = 1'b0; r.pre = 0;
    end else begin
      tick = (m.pre == presc - 1);
      r.pre = tick ? 0 : m.pre + 1;
    end
    if (lo > hi) return r;
    if (load) begin
      r.count = (lv < lo) ? lo : (lv > hi) ? hi : lv;
    end else if (enable && tick) begin
      s   = (step == 2'd0) ? 1 : int'(step);
      up  = (mode == 2'd2) ? m.dir : up_down;
      tgt = up ? m.count + s : m.count - s;
      r.dir = up;
      if (up && tgt > hi) begin
        r.pulse = 1'b1;
        if (mode == 2'd1) r.count = hi;
        else if (mode == 2'd2) begin r.count = hi; r.dir = 1'b0; end
        else r.count = lo;
      end else if (!up && tgt < lo) begin
        r.pulse = 1'b1;
        if (mode == 2'd1) r.count = lo;
        else if (mode == 2'd2) begin r.count = lo; r.dir = 1'b1; end
        else r.count = hi;
      end else if (m.count < lo || m.count > hi) begin
        r.pulse = 1'b1;
        r.count = (tgt < lo) ? lo : (tgt > hi) ? hi : tgt;
      end else begin
        r.count = tgt;
      end
    end
    r.sticky = r.pulse || (m.sticky && !clear_flags);
    return r;
  endfunction

  task automatic check_all();
    check_val("p1_count", 32'(c1_count), 32'(m1.count));
    check_val("p1_dir", 32'(c1_dir), 32'(m1.dir));
    check_val("p1_pulse", 32'(c1_pulse), 32'(m1.pulse));
    check_val("p1_sticky", 32'(c1_sticky), 32'(m1.sticky));
    check_val("p1_at_max", 32'(c1_at_max), 32'(m1.count == int'(hi_limit)));
    check_val("p1_at_min", 32'(c1_at_min), 32'(m1.count == int'(lo_limit)));
    check_val("p1_limit_err", 32'(c1_err), 32'(lo_limit > hi_limit));
    check_val("p3_count", 32'(c3_count), 32'(m3.count));
    check_val("p3_dir", 32'(c3_dir), 32'(m3.dir));
    check_val("p3_pulse", 32'(c3_pulse), 32'(m3.pulse));
    check_val("p3_sticky", 32'(c3_sticky), 32'(m3.sticky));
    check_val("p3_at_max", 32'(c3_at_max), 32'(m3.count == int'(hi_limit)));
  endtask

  task automatic cycle();
    m1 = model_next(m1, 1);
    m3 = model_next(m3, 3);
    @(posedge clk);
    #1;
    cyc++;
    $display("cyc %0d en=%0b ld=%0b lv=%0d ud=%0b st=%0d md=%0d lo=%0d hi=%0d clr=%0b | p1 cnt=%0d ev=%0b | p3 cnt=%0d ev=%0b",
             cyc, enable, load, load_value, up_down, step, mode, lo_limit, hi_limit, clear_flags,
             c1_count, c1_pulse, c3_count, c3_pulse);
    check_all();
  endtask

  task automatic async_reset_check();
    #3 reset = 1'b1;
    #1;
    check_val("async_p1_count", 32'(c1_count), 32'd5);
    check_val("async_p3_count", 32'(c3_count), 32'd5);
    check_val("async_p1_dir", 32'(c1_dir), 32'd1);
    check_val("async_p1_sticky", 32'(c1_sticky), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    m1 = model_reset();
    m3 = model_reset();
  endtask

  initial begin
    reset = 1'b1; enable = 0; load = 0; load_value = 0; up_down = 1; clear_flags = 0;
    step = 2'd1; mode = 2'd0; lo_limit = 4'd0; hi_limit = 4'd15;
    m1 = model_reset();
    m3 = model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_val("rst_count", 32'(c1_count), 32'd5);
    check_val("rst_dir", 32'(c1_dir), 32'd1);
    check_val("rst_pulse", 32'(c1_pulse), 32'd0);
    check_val("rst_sticky", 32'(c1_sticky), 32'd0);

    // Wrap from the top of the full range.
    enable = 1;
    repeat (10) cycle();
    check_val("wrap_at_max", 32'(c1_at_max), 32'd1);
    check_val("wrap_top", 32'(c1_count), 32'd15);
    cycle();
    check_val("wrap_zero", 32'(c1_count), 32'd0);
    check_val("wrap_pulse", 32'(c1_pulse), 32'd1);
    check_val("wrap_sticky", 32'(c1_sticky), 32'd1);

    // Saturate: start at 8 in [2,9] with step 3.
    mode = 2'd1; lo_limit = 4'd2; hi_limit = 4'd9; enable = 0; load = 1; load_value = 4'd8;
    cycle();
    load = 0; enable = 1; step = 2'd3;
    repeat (3) begin
      cycle();
      check_val("sat_hold", 32'(c1_count), 32'd9);
      check_val("sat_pulse", 32'(c1_pulse), 32'd1);
    end

    // Bounce in [3,6] with up_down toggling underneath.
    mode = 2'd2; lo_limit = 4'd3; hi_limit = 4'd6; step = 2'd1; enable = 0; load = 1; load_value = 4'd5;
    cycle();
    load = 0; enable = 1;
    repeat (8) begin
      up_down = ~up_down;
      cycle();
    end

    // Load beats enable and is clamped; inverted limits freeze everything.
    mode = 2'd0; lo_limit = 4'd0; hi_limit = 4'd10; load = 1; load_value = 4'd12;
    cycle();
    check_val("load_clamp", 32'(c1_count), 32'd10);
    check_val("load_no_event", 32'(c1_pulse), 32'd0);
    lo_limit = 4'd11;
    repeat (3) begin
      load = ~load;
      cycle();
      check_val("frozen_count", 32'(c1_count), 32'd10);
      check_val("frozen_err", 32'(c1_err), 32'd1);
    end

    // Random traffic with occasional limit/mode changes and an async reset.
    load = 0; lo_limit = 4'd0; hi_limit = 4'd15;
    for (int i = 0; i < 600; i++) begin
      enable      = ($urandom_range(0, 99) < 85);
      load        = ($urandom_range(0, 99) < 5);
      load_value  = 4'($urandom);
      up_down     = ($urandom_range(0, 99) < 60);
      step        = 2'($urandom);
      clear_flags = ($urandom_range(0, 99) < 10);
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        lo_limit = 4'($urandom);
        hi_limit = 4'($urandom);
        if ($urandom_range(0, 7) != 0 && lo_limit > hi_limit) begin
          load_value = lo_limit;
          lo_limit   = hi_limit;
          hi_limit   = load_value;
        end
      end
      cycle();
      if (i == 300) async_reset_check();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
